// File: rtl/seg_scan_display_pkg.sv
// Shared seven-segment constants for the nibble display path.
// Latency: none (constants only).
// Backpressure: none.
package seg_scan_display_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments dark, and all anodes released
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// Hex nibble to active-low seven-segment decoder (0-F).
// Latency: purely combinational.
// Backpressure: none.
module hex7seg
  import seg_scan_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Direct lookup; every nibble value has a glyph so no default is reachable
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame tear-free snapshot.
// Latency: outputs registered, 1 cycle behind digit index/snapshot; snapshot once per 4*REFRESH_DIV cycles.
// Backpressure: none; Q_in is sampled only at frame boundaries, dp_in/blank_lz every cycle.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Q_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          fd_q, fd_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    nib_seg;
  logic          blank3, blank2, blank1, cur_blank;

  assign tick = (cnt_q == CNT_MAX);
  assign nib  = 4'(snap_q >> {idx_q, 2'b00});

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  // Leading-zero blanking chains downward from the most significant digit
  always_comb begin
    blank3    = blank_lz && (snap_q[15:12] == 4'h0);
    blank2    = blank3 && (snap_q[11:8] == 4'h0);
    blank1    = blank2 && (snap_q[7:4] == 4'h0);
    cur_blank = 1'b0;
    case (idx_q)
      2'd3:    cur_blank = blank3;
      2'd2:    cur_blank = blank2;
      2'd1:    cur_blank = blank1;
      default: cur_blank = 1'b0;
    endcase
  end

  // Prescaler, digit advance, frame snapshot and the next registered display values
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    fd_d   = 1'b0;
    if (tick && (idx_q == 2'd3)) begin
      snap_d = Q_in;
      fd_d   = 1'b1;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = cur_blank ? SEG_BLANK : nib_seg;
    dp_d  = cur_blank ? 1'b1 : ~dp_in[idx_q];
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      fd_q   <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      fd_q   <= fd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with a frame-level reference model.
// Driver pushes the expected post-edge outputs; monitor pops and compares after each edge.
// Inputs change on falling edges, outputs are sampled 1 time unit after rising edges.
module tb_seg_scan_display;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Q_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  exp_t sb_q[$];

  // Reference state: rising edges since reset release, and the value on display
  int          k      = 0;
  logic [15:0] m_snap = 16'h0000;

  logic [6:0] codes [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_display #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .Q_in       (Q_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Apply inputs for the next rising edge and push what the display must show after it
  task automatic step(input logic rst, input logic [15:0] q, input logic [3:0] dpi, input logic blz);
    exp_t e;
    int   d;
    int   top;
    logic [3:0] n;
    logic blanked;
    reset    = rst;
    Q_in     = q;
    dp_in    = dpi;
    blank_lz = blz;
    if (rst) begin
      e      = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
      k      = 0;
      m_snap = 16'h0000;
    end else begin
      k++;
      d   = ((k - 1) / RD) % 4;
      n   = 4'((m_snap >> (4 * d)) & 16'hF);
      top = 0;
      for (int i = 0; i < 4; i++)
        if (((m_snap >> (4 * i)) & 16'hF) != 0) top = i;
      blanked = blz && (d > top);
      e.an    = ~(4'b0001 << d);
      e.seg   = blanked ? 7'b1111111 : codes[n];
      e.dp    = blanked ? 1'b1 : ~dpi[d];
      e.fd    = (k % FRAME) == 0;
      if (e.fd) m_snap = q;
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [15:0] q, input logic [3:0] dpi, input logic blz);
    for (int i = 0; i < n; i++) step(1'b0, q, dpi, blz);
  endtask

  // Monitor: one expected entry per rising edge once the driver has started
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rq;
    logic [3:0]  rdp;
    logic        rblz;
    // Reset, then first frame of zeros followed by the 9A3F frame
    for (int i = 0; i < 3; i++) step(1'b1, 16'h9A3F, 4'h0, 1'b0);
    run(2 * FRAME, 16'h9A3F, 4'h0, 1'b0);
    // Tear-free: capture 1234, then swap to 5678 while digit 1 is lit
    run(FRAME, 16'h1234, 4'h0, 1'b0);
    run(6, 16'h1234, 4'h0, 1'b0);
    run(FRAME - 6 + FRAME, 16'h5678, 4'h0, 1'b0);
    // Leading-zero blanking and decimal point interaction
    run(2 * FRAME, 16'h0050, 4'h0, 1'b1);
    run(2 * FRAME, 16'h0000, 4'h0, 1'b1);
    run(2 * FRAME, 16'h0000, 4'b0100, 1'b1);
    run(2 * FRAME, 16'h0000, 4'b0100, 1'b0);
    run(2 * FRAME, 16'h0A07, 4'b1111, 1'b1);
    // Reset while digit 2 is active
    while (((k / RD) % 4) != 2) step(1'b0, 16'h4321, 4'h0, 1'b0);
    step(1'b1, 16'h4321, 4'h0, 1'b0);
    run(3 * FRAME, 16'h4321, 4'h0, 1'b0);
    // Randomized traffic, biased toward values with leading zeros
    rq = 16'h0; rdp = 4'h0; rblz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        rq = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) rdp = 4'($urandom);
      if ($urandom_range(0, 31) == 0) rblz = 1'($urandom);
      step($urandom_range(0, 199) == 0, rq, rdp, rblz);
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
